// File: rtl/emif_sdram_decoder.sv
// Purpose : decodes the SDRAM command set arriving from the EMIF pin synchronisers into
//           per-beat FPGA read/write strobes, with a per-bank open-row table and a CAS-aligned read drive enable.
// Latency : every output is registered and follows its sampling EMIF edge by 1 clk; rd_oe trails a READ by CAS_LAT edges.
// Backpressure : none; the SDRAM protocol is free-running, so every edge is consumed.
// Ports   : clk/rst_n     - system clock, async active-low reset
//           emif_*        - synchronised EMIF pins plus the emif_clk_en edge marker
//           fpga_read/fpga_write/bus_addr/byte_en - per-beat fabric access
//           rd_oe         - read data drive enable; burst_active - burst in progress; cmd_err - access to a closed bank
module emif_sdram_decoder #(
  parameter int ADDR_W    = 13,
  parameter int BA_W      = 2,
  parameter int COL_W     = 9,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2,
  parameter int DQM_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          emif_clk_en,
  input  logic                          emif_cs_n,
  input  logic                          emif_ras_n,
  input  logic                          emif_cas_n,
  input  logic                          emif_we_n,
  input  logic [BA_W-1:0]               emif_ba,
  input  logic [ADDR_W-1:0]             emif_addr,
  input  logic [DQM_W-1:0]              emif_dqm,
  output logic                          fpga_read,
  output logic                          fpga_write,
  output logic [BA_W+ADDR_W+COL_W-1:0]  bus_addr,
  output logic [DQM_W-1:0]              byte_en,
  output logic                          rd_oe,
  output logic                          burst_active,
  output logic                          cmd_err
);

  localparam int NB = 1 << BA_W;
  // Low column bits that wrap inside a burst; upper bits stay fixed.
  localparam logic [COL_W-1:0] WRAP_MASK = COL_W'(BURST_LEN - 1);
  localparam logic [COL_W-1:0] LAST_BEAT = COL_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t             state;
  logic [NB-1:0]      bank_open;
  logic [ADDR_W-1:0]  row [NB];
  logic [BA_W-1:0]    cur_bank;
  logic [COL_W-1:0]   start_col;
  logic [COL_W-1:0]   beat;      // index of the next beat to issue
  logic [CAS_LAT:0]   rd_pipe;   // stage 0 = beat issued on the latest edge

  logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_bst;

  always_comb begin
    cmd_act = 1'b0;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    cmd_pre = 1'b0;
    cmd_bst = 1'b0;
    if (!emif_cs_n) begin
      case ({emif_ras_n, emif_cas_n, emif_we_n})
        3'b011:  cmd_act = 1'b1;
        3'b101:  cmd_rd  = 1'b1;
        3'b100:  cmd_wr  = 1'b1;
        3'b010:  cmd_pre = 1'b1;
        3'b110:  cmd_bst = 1'b1;
        default: ;
      endcase
    end
  end

  logic             bank_ok, start_rd, start_wr, start, cmd_bad;
  logic             in_burst, pre_hit, stop, cont, rd_beat, wr_beat;
  logic [COL_W-1:0] cont_col;
  logic [BA_W+ADDR_W+COL_W-1:0] beat_addr;

  assign bank_ok   = bank_open[emif_ba];
  assign start_rd  = cmd_rd & bank_ok;
  assign start_wr  = cmd_wr & bank_ok;
  assign start     = start_rd | start_wr;
  assign cmd_bad   = (cmd_rd | cmd_wr) & ~bank_ok;
  assign in_burst  = (state != IDLE);
  // Precharging the bank a burst is using kills that burst on the same edge.
  assign pre_hit   = cmd_pre & (emif_addr[10] | (emif_ba == cur_bank));
  assign stop      = in_burst & ~start & (cmd_bst | pre_hit);
  // Any other edge inside a burst (NOP, deselect, ACTIVE, rejected access) advances it.
  assign cont      = in_burst & ~start & ~stop;
  assign cont_col  = (start_col & ~WRAP_MASK) | ((start_col + beat) & WRAP_MASK);
  assign rd_beat   = start_rd | (cont & (state == RD_BURST));
  assign wr_beat   = start_wr | (cont & (state == WR_BURST));
  assign beat_addr = start ? {emif_ba, row[emif_ba], emif_addr[COL_W-1:0]}
                           : {cur_bank, row[cur_bank], cont_col};

  assign rd_oe = rd_pipe[CAS_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bank_open    <= '0;
      for (int i = 0; i < NB; i++) row[i] <= '0;
      cur_bank     <= '0;
      start_col    <= '0;
      beat         <= '0;
      rd_pipe      <= '0;
      fpga_read    <= 1'b0;
      fpga_write   <= 1'b0;
      bus_addr     <= '0;
      byte_en      <= '0;
      burst_active <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      fpga_read  <= 1'b0;
      fpga_write <= 1'b0;
      cmd_err    <= 1'b0;
      if (emif_clk_en) begin
        cmd_err    <= cmd_bad;
        fpga_read  <= rd_beat;
        fpga_write <= wr_beat;
        if (rd_beat || wr_beat) begin
          bus_addr <= beat_addr;
          byte_en  <= ~emif_dqm;
        end
        // An accepted WRITE flushes pending read data; a terminate lets it drain.
        rd_pipe <= start_wr ? '0 : {rd_pipe[CAS_LAT-1:0], rd_beat};

        if (cmd_act) begin
          row[emif_ba]       <= emif_addr;
          bank_open[emif_ba] <= 1'b1;
        end
        if (cmd_pre) begin
          if (emif_addr[10]) bank_open <= '0;
          else               bank_open[emif_ba] <= 1'b0;
        end

        if (start) begin
          cur_bank  <= emif_ba;
          start_col <= emif_addr[COL_W-1:0];
          beat      <= COL_W'(1);
          if (BURST_LEN == 1) begin
            state        <= IDLE;
            burst_active <= 1'b0;
          end else begin
            state        <= start_rd ? RD_BURST : WR_BURST;
            burst_active <= 1'b1;
          end
        end else if (stop) begin
          state        <= IDLE;
          burst_active <= 1'b0;
        end else if (cont) begin
          beat <= beat + COL_W'(1);
          if (beat == LAST_BEAT) begin
            state        <= IDLE;
            burst_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule
